// File: rtl/cpu_bus_arbiter.sv
// Zero-cycle arbiter that muxes N SRAM-like master channels onto one downstream bus and routes responses back in issue order.
// Optional round-robin grant when CPU_BUS_ARBITER_ROUND_ROBIN_EN is defined; default build is fixed priority (lowest index wins).
//
// state      | meaning
// ARB_OPEN   | no pending presentation; grant chosen freshly each cycle
// ARB_LOCKED | a request was presented but not accepted; grant pinned to lock_idx

module cpu_bus_arbiter #(
    parameter int CHANNEL_COUNT   = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [CHANNEL_COUNT-1:0]            channel_request,
    input  logic [CHANNEL_COUNT-1:0]            channel_write,
    input  logic [2*CHANNEL_COUNT-1:0]          channel_size,
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] channel_address,
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] channel_write_data,
    input  logic [4*CHANNEL_COUNT-1:0]          channel_write_strobe,
    output logic [CHANNEL_COUNT-1:0]            channel_address_ready,
    output logic [CHANNEL_COUNT-1:0]            channel_data_ready,
    output logic [DATA_WIDTH-1:0]               channel_read_data,
    output logic                                bus_request,
    output logic                                bus_write,
    output logic [1:0]                          bus_size,
    output logic [DATA_WIDTH-1:0]               bus_address,
    output logic [DATA_WIDTH-1:0]               bus_write_data,
    output logic [3:0]                          bus_write_strobe,
    input  logic [DATA_WIDTH-1:0]               bus_read_data,
    input  logic                                bus_address_ready,
    input  logic                                bus_data_ready
);

    localparam int CH_W  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CH_W-1:0]  lock_idx_q;
    logic [CH_W-1:0]  lock_idx_d;

    logic             grant_valid;
    logic [CH_W-1:0]  grant_idx;
    logic             tracker_full;
    logic             bus_request_int;
    logic             push;
    logic             pop;

    logic [CH_W-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    logic [CH_W-1:0]  rr_ptr;
`endif

    assign tracker_full = (count == CNT_W'(MAX_OUTSTANDING));

    // Grant selection: a locked channel always wins, otherwise search by policy.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (state_q == ARB_LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
                cand = (int'(rr_ptr) + k) % CHANNEL_COUNT;
`else
                cand = k;
`endif
                if (!grant_valid && channel_request[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(cand);
                end
            end
        end
    end

    assign bus_request_int = grant_valid && channel_request[grant_idx] && !tracker_full && !reset;
    assign bus_request     = bus_request_int;
    assign push            = bus_request_int && bus_address_ready;
    assign pop             = bus_data_ready && (count != '0) && !reset;

    always_comb begin
        bus_write        = 1'b0;
        bus_size         = '0;
        bus_address      = '0;
        bus_write_data   = '0;
        bus_write_strobe = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            if (grant_valid && grant_idx == CH_W'(k)) begin
                bus_write        = channel_write[k];
                bus_size         = channel_size[2*k +: 2];
                bus_address      = channel_address[DATA_WIDTH*k +: DATA_WIDTH];
                bus_write_data   = channel_write_data[DATA_WIDTH*k +: DATA_WIDTH];
                bus_write_strobe = channel_write_strobe[4*k +: 4];
            end
        end
    end

    always_comb begin
        channel_address_ready = '0;
        channel_data_ready    = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            channel_address_ready[k] = bus_address_ready && grant_valid &&
                                       (grant_idx == CH_W'(k)) && !tracker_full && !reset;
            channel_data_ready[k]    = pop && (fifo_mem[rd_ptr] == CH_W'(k));
        end
    end

    assign channel_read_data = bus_read_data;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (push) begin
            state_d = ARB_OPEN;
        end else if (bus_request_int) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = grant_idx;
        end else if (state_q == ARB_LOCKED && !channel_request[lock_idx_q]) begin
            // Master withdrew its request; release rather than pin the bus forever.
            state_d = ARB_OPEN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_OPEN;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // In-order tracker of issued channel indices; a pop while full never frees a slot this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= grant_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            if (int'(grant_idx) == CHANNEL_COUNT - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios followed by random traffic against a queue-based reference model.
// Follows CPU_BUS_ARBITER_ROUND_ROBIN_EN to pick the expected grant policy.

module tb_cpu_bus_arbiter;

    localparam int CH = 2;
    localparam int DW = 32;
    localparam int MO = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [CH-1:0]     channel_request;
    logic [CH-1:0]     channel_write;
    logic [2*CH-1:0]   channel_size;
    logic [DW*CH-1:0]  channel_address;
    logic [DW*CH-1:0]  channel_write_data;
    logic [4*CH-1:0]   channel_write_strobe;
    logic [CH-1:0]     channel_address_ready;
    logic [CH-1:0]     channel_data_ready;
    logic [DW-1:0]     channel_read_data;
    logic              bus_request;
    logic              bus_write;
    logic [1:0]        bus_size;
    logic [DW-1:0]     bus_address;
    logic [DW-1:0]     bus_write_data;
    logic [3:0]        bus_write_strobe;
    logic [DW-1:0]     bus_read_data;
    logic              bus_address_ready;
    logic              bus_data_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pinned channel (-1 none), next round-robin start, FIFO of issued channels.
    int lock_ch = -1;
    int rr_next = 0;
    int trk[$];

    int            m_gnt;
    bit            m_ebr;
    logic [CH-1:0] m_accepted;
    logic [CH-1:0] pending;

    cpu_bus_arbiter #(.CHANNEL_COUNT(CH), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock                (clock),
        .reset                (reset),
        .channel_request      (channel_request),
        .channel_write        (channel_write),
        .channel_size         (channel_size),
        .channel_address      (channel_address),
        .channel_write_data   (channel_write_data),
        .channel_write_strobe (channel_write_strobe),
        .channel_address_ready(channel_address_ready),
        .channel_data_ready   (channel_data_ready),
        .channel_read_data    (channel_read_data),
        .bus_request          (bus_request),
        .bus_write            (bus_write),
        .bus_size             (bus_size),
        .bus_address          (bus_address),
        .bus_write_data       (bus_write_data),
        .bus_write_strobe     (bus_write_strobe),
        .bus_read_data        (bus_read_data),
        .bus_address_ready    (bus_address_ready),
        .bus_data_ready       (bus_data_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs, predict them from the model and compare.
    task automatic eval_cycle();
        bit            full;
        logic [CH-1:0] ecar;
        logic [CH-1:0] ecdr;
        #2;
        full  = (trk.size() == MO);
        m_gnt = -1;
        if (lock_ch >= 0) begin
            m_gnt = lock_ch;
        end else begin
            for (int k = 0; k < CH; k++) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
                int c = (rr_next + k) % CH;
`else
                int c = k;
`endif
                if (m_gnt < 0 && channel_request[c]) m_gnt = c;
            end
        end
        m_ebr = !reset && m_gnt >= 0 && channel_request[m_gnt] && !full;
        ecar  = '0;
        if (!reset && m_gnt >= 0 && bus_address_ready && !full) ecar[m_gnt] = 1'b1;
        ecdr  = '0;
        if (!reset && bus_data_ready && trk.size() > 0) ecdr[trk[0]] = 1'b1;
        m_accepted = ecar & channel_request;

        check("bus_request", 64'(bus_request), 64'(m_ebr));
        check("channel_address_ready", 64'(channel_address_ready), 64'(ecar));
        check("channel_data_ready", 64'(channel_data_ready), 64'(ecdr));
        check("channel_read_data", 64'(channel_read_data), 64'(bus_read_data));
        if (m_ebr) begin
            check("bus_address", 64'(bus_address), 64'(channel_address[m_gnt*DW +: DW]));
            check("bus_write", 64'(bus_write), 64'(channel_write[m_gnt]));
            check("bus_size", 64'(bus_size), 64'(channel_size[m_gnt*2 +: 2]));
            check("bus_write_data", 64'(bus_write_data), 64'(channel_write_data[m_gnt*DW +: DW]));
            check("bus_write_strobe", 64'(bus_write_strobe), 64'(channel_write_strobe[m_gnt*4 +: 4]));
        end
    endtask

    // Advance the model by one clock using the inputs just evaluated, then step the DUT.
    task automatic commit_cycle();
        if (reset) begin
            trk.delete();
            lock_ch = -1;
            rr_next = 0;
        end else begin
            if (bus_data_ready && trk.size() > 0) void'(trk.pop_front());
            if (m_ebr && bus_address_ready) begin
                trk.push_back(m_gnt);
                lock_ch = -1;
                rr_next = (m_gnt + 1) % CH;
            end else if (m_ebr) begin
                lock_ch = m_gnt;
            end else if (lock_ch >= 0 && !channel_request[lock_ch]) begin
                lock_ch = -1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        eval_cycle();
        commit_cycle();
    endtask

    task automatic set_ch(input int c, input bit req, input bit wr, input logic [DW-1:0] addr);
        channel_request[c]              = req;
        channel_write[c]                = wr;
        channel_size[c*2 +: 2]          = 2'd2;
        channel_address[c*DW +: DW]     = addr;
        channel_write_data[c*DW +: DW]  = addr ^ 32'h5A5A_0000;
        channel_write_strobe[c*4 +: 4]  = 4'hF;
    endtask

    task automatic idle_inputs();
        channel_request   = '0;
        bus_address_ready = 1'b0;
        bus_data_ready    = 1'b0;
        bus_read_data     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        eval_cycle();
        check("reset_bus_request", 64'(bus_request), 64'd0);
        commit_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        channel_request      = '0;
        channel_write        = '0;
        channel_size         = '0;
        channel_address      = '0;
        channel_write_data   = '0;
        channel_write_strobe = '0;
        bus_read_data        = '0;
        bus_address_ready    = 1'b0;
        bus_data_ready       = 1'b0;
        pending              = '0;
        @(posedge clock);
        #1;

        // Reset holds outputs quiet even with live inputs.
        set_ch(0, 1'b1, 1'b0, 32'h0000_2000);
        bus_address_ready = 1'b1;
        bus_data_ready    = 1'b1;
        eval_cycle();
        check("rst_live_car", 64'(channel_address_ready), 64'd0);
        check("rst_live_cdr", 64'(channel_data_ready), 64'd0);
        commit_cycle();
        do_reset();

        // Single read on ch0, response two cycles later.
        set_ch(0, 1'b1, 1'b0, 32'h0000_1000);
        bus_address_ready = 1'b1;
        eval_cycle();
        check("rd_bus_address", 64'(bus_address), 64'h1000);
        check("rd_car", 64'(channel_address_ready), 64'b01);
        commit_cycle();
        idle_inputs();
        step();
        bus_data_ready = 1'b1;
        bus_read_data  = 32'hDEAD_BEEF;
        eval_cycle();
        check("rd_cdr", 64'(channel_data_ready), 64'b01);
        check("rd_data", 64'(channel_read_data), 64'hDEAD_BEEF);
        commit_cycle();

        // Both channels request continuously.
        do_reset();
        set_ch(0, 1'b1, 1'b0, 32'h0000_0100);
        set_ch(1, 1'b1, 1'b1, 32'h0000_0200);
        bus_address_ready = 1'b1;
        bus_data_ready    = 1'b1;
        for (int n = 0; n < 4; n++) begin
            eval_cycle();
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
            check("both_rr_grant", 64'(channel_address_ready), (n % 2 == 0) ? 64'b01 : 64'b10);
`else
            check("both_fixed_grant", 64'(channel_address_ready), 64'b01);
`endif
            commit_cycle();
        end

        // Lock: ch1 held off three cycles while ch0 joins.
        do_reset();
        set_ch(1, 1'b1, 1'b0, 32'h0000_0300);
        eval_cycle();
        check("lock_c1_present", 64'(bus_address), 64'h0300);
        commit_cycle();
        set_ch(0, 1'b1, 1'b0, 32'h0000_0400);
        eval_cycle();
        check("lock_c2_hold", 64'(bus_address), 64'h0300);
        commit_cycle();
        eval_cycle();
        check("lock_c3_hold", 64'(bus_address), 64'h0300);
        commit_cycle();
        bus_address_ready = 1'b1;
        eval_cycle();
        check("lock_c4_accept", 64'(channel_address_ready), 64'b10);
        commit_cycle();
        channel_request[1] = 1'b0;
        eval_cycle();
        check("lock_c5_next", 64'(channel_address_ready), 64'b01);
        commit_cycle();

        // Tracker full: four issues, fifth blocked, a pop frees the slot a cycle later.
        do_reset();
        bus_address_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            channel_request = '0;
            set_ch(n % 2, 1'b1, 1'b0, 32'h1000 + 32'(n));
            step();
        end
        channel_request = '0;
        set_ch(0, 1'b1, 1'b0, 32'h0000_2000);
        eval_cycle();
        check("full_block", 64'(bus_request), 64'd0);
        commit_cycle();
        bus_data_ready = 1'b1;
        eval_cycle();
        check("full_pop_still_block", 64'(bus_request), 64'd0);
        check("full_pop_order0", 64'(channel_data_ready), 64'b01);
        commit_cycle();
        bus_data_ready = 1'b0;
        eval_cycle();
        check("full_resume", 64'(bus_request), 64'd1);
        commit_cycle();
        channel_request = '0;
        bus_data_ready  = 1'b1;
        for (int n = 1; n < 5; n++) begin
            eval_cycle();
            check("full_order", 64'(channel_data_ready), (n % 2 == 1) ? 64'b10 : 64'b01);
            commit_cycle();
        end

        // Reset discards in-flight entries.
        do_reset();
        bus_address_ready = 1'b1;
        set_ch(1, 1'b1, 1'b0, 32'h0000_0500);
        step();
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset          = 1'b0;
        bus_data_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            eval_cycle();
            check("post_reset_drop", 64'(channel_data_ready), 64'd0);
            commit_cycle();
        end
        bus_data_ready    = 1'b0;
        bus_address_ready = 1'b1;
        set_ch(0, 1'b1, 1'b0, 32'h0000_0600);
        step();
        idle_inputs();
        bus_data_ready = 1'b1;
        eval_cycle();
        check("post_reset_fresh", 64'(channel_data_ready), 64'b01);
        commit_cycle();

        // Random traffic; masters hold each request and its fields until accepted.
        do_reset();
        pending = '0;
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            for (int c = 0; c < CH; c++) begin
                if (!pending[c] && $urandom_range(0, 1) == 1) begin
                    pending[c] = 1'b1;
                    channel_write[c]               = 1'($urandom_range(0, 1));
                    channel_size[c*2 +: 2]         = 2'($urandom_range(0, 3));
                    channel_address[c*DW +: DW]    = $urandom;
                    channel_write_data[c*DW +: DW] = $urandom;
                    channel_write_strobe[c*4 +: 4] = 4'($urandom_range(0, 15));
                end
                channel_request[c] = pending[c];
            end
            bus_address_ready = ($urandom_range(0, 3) != 0);
            bus_data_ready    = ($urandom_range(0, 2) == 0);
            bus_read_data     = $urandom;
            step();
            pending = pending & ~m_accepted;
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
